// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: HI/LO owner that sequences external unsigned Mult/Div units with signed fix-up and stall
module hilo_muldiv_ctrl #(
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           op_valid,
  input  logic [OPW-1:0] op,
  input  logic [31:0]    src_a,
  input  logic [31:0]    src_b,
  output logic           stall,
  output logic [31:0]    mf_result,
  output logic [31:0]    hi,
  output logic [31:0]    lo,
  output logic           div_zero,
  output logic [31:0]    unit_a,
  output logic [31:0]    unit_b,
  output logic           mul_valid_in,
  input  logic           mul_valid_out,
  input  logic [31:0]    mul_hi,
  input  logic [31:0]    mul_lo,
  output logic           div_valid_in,
  input  logic           div_valid_out,
  input  logic [31:0]    div_hi,
  input  logic [31:0]    div_lo
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] WRITE  = 2'd3;
  logic [1:0]  r_state;
  logic        r_kind;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [31:0] r_res_hi;
  logic [31:0] r_res_lo;
  logic        w_idle;
  logic        w_md;
  logic        w_is_div;
  logic        w_signed;
  logic        w_dz;
  logic        w_go;
  logic        w_vo;
  logic        w_mt_hi;
  logic        w_mt_lo;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [63:0] w_res;
  logic [63:0] w_fix;
  assign w_idle   = r_state == IDLE;
  assign w_md     = op_valid && w_idle && op >= OPW'(1) && op <= OPW'(4);
  assign w_is_div = op == OPW'(3) || op == OPW'(4);
  assign w_signed = op == OPW'(1) || op == OPW'(3);
  assign w_dz     = w_md && w_is_div && src_b == 32'd0;
  assign w_go     = w_md && !w_dz;
  assign w_mt_hi  = op_valid && w_idle && op == OPW'(5);
  assign w_mt_lo  = op_valid && w_idle && op == OPW'(6);
  assign w_abs_a  = (w_signed && src_a[31]) ? -src_a : src_a;
  assign w_abs_b  = (w_signed && src_b[31]) ? -src_b : src_b;
  assign w_vo     = r_kind ? div_valid_out : mul_valid_out;
  assign w_res    = {r_res_hi, r_res_lo};
  // Division signs the quotient and remainder separately; the product is negated as one 64-bit value.
  assign w_fix    = r_kind ? {(r_neg_r ? -r_res_hi : r_res_hi), (r_neg_q ? -r_res_lo : r_res_lo)}
                           : (r_neg_q ? -w_res : w_res);
  assign stall     = w_go || r_state == LAUNCH || r_state == WAIT;
  assign mf_result = (op_valid && op == OPW'(7)) ? hi : (op_valid && op == OPW'(8)) ? lo : 32'd0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_kind       <= 1'b0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_res_hi     <= 32'd0;
      r_res_lo     <= 32'd0;
      hi           <= 32'd0;
      lo           <= 32'd0;
      unit_a       <= 32'd0;
      unit_b       <= 32'd0;
      mul_valid_in <= 1'b0;
      div_valid_in <= 1'b0;
      div_zero     <= 1'b0;
    end else begin
      mul_valid_in <= w_go && !w_is_div;
      div_valid_in <= w_go && w_is_div;
      div_zero     <= w_dz;
      if (w_go) begin
        unit_a  <= w_abs_a;
        unit_b  <= w_abs_b;
        r_neg_q <= w_signed && (src_a[31] ^ src_b[31]);
        r_neg_r <= w_signed && src_a[31];
        r_kind  <= w_is_div;
        r_state <= LAUNCH;
      end else if (r_state == LAUNCH) begin
        r_state <= WAIT;
      end else if (r_state == WAIT && w_vo) begin
        r_res_hi <= r_kind ? div_hi : mul_hi;
        r_res_lo <= r_kind ? div_lo : mul_lo;
        r_state  <= WRITE;
      end else if (r_state == WRITE) begin
        hi      <= w_fix[63:32];
        lo      <= w_fix[31:0];
        r_state <= IDLE;
      end
      if (w_mt_hi) hi <= src_a;
      if (w_mt_lo) lo <= src_a;
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: randomized and directed checks of the HI/LO mult/div controller against a behavioural model
module tb_hilo_muldiv_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] src_a, src_b;
  logic        stall;
  logic [31:0] mf_result, hi, lo;
  logic        div_zero;
  logic [31:0] unit_a, unit_b;
  logic        mul_valid_in, mul_valid_out;
  logic [31:0] mul_hi, mul_lo;
  logic        div_valid_in, div_valid_out;
  logic [31:0] div_hi, div_lo;
  int total = 0;
  int bad = 0;
  logic [31:0] m_hi = 0;
  logic [31:0] m_lo = 0;
  hilo_muldiv_ctrl #(.OPW(4)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .src_a(src_a), .src_b(src_b),
    .stall(stall), .mf_result(mf_result), .hi(hi), .lo(lo), .div_zero(div_zero),
    .unit_a(unit_a), .unit_b(unit_b),
    .mul_valid_in(mul_valid_in), .mul_valid_out(mul_valid_out), .mul_hi(mul_hi), .mul_lo(mul_lo),
    .div_valid_in(div_valid_in), .div_valid_out(div_valid_out), .div_hi(div_hi), .div_lo(div_lo)
  );
  always #5 clk = ~clk;
  task automatic test_reset();
    reset = 1'b1;
    op_valid = 1'b0; op = 4'd0; src_a = 32'd0; src_b = 32'd0;
    mul_valid_out = 1'b0; div_valid_out = 1'b0;
    mul_hi = 32'd0; mul_lo = 32'd0; div_hi = 32'd0; div_lo = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got %b want 0", stall); end
    total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL reset_hilo got %h want 0", {hi, lo}); end
    total++; if ({unit_a, unit_b} !== 64'd0) begin bad++; $display("FAIL reset_unit got %h want 0", {unit_a, unit_b}); end
    total++; if ({mul_valid_in, div_valid_in, div_zero} !== 3'b000) begin bad++; $display("FAIL reset_pulses got %b want 000", {mul_valid_in, div_valid_in, div_zero}); end
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic run_md(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input int lat, input string nm);
    logic sgn, isdiv, launched, done;
    logic [31:0] ma, mb;
    logic [63:0] ures, exp;
    longint sa, sb, q, r;
    int stalls, mv, dv, wc;
    sgn = (o == 4'd1 || o == 4'd3);
    isdiv = (o == 4'd3 || o == 4'd4);
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    ures = isdiv ? {ma % mb, ma / mb} : 64'(ma) * 64'(mb);
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    if (isdiv) begin
      q = sa / sb;
      r = sa % sb;
      exp = {r[31:0], q[31:0]};
    end else begin
      q = sa * sb;
      exp = q;
    end
    stalls = 0; mv = 0; dv = 0; wc = 0; launched = 1'b0; done = 1'b0;
    mul_hi = ures[63:32]; mul_lo = ures[31:0]; div_hi = ures[63:32]; div_lo = ures[31:0];
    @(negedge clk);
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    for (int c = 0; c < 80 && !done; c++) begin
      #1;
      if (stall) stalls++;
      if (mul_valid_in) mv++;
      if (div_valid_in) dv++;
      if (launched) wc++;
      if (mul_valid_in || div_valid_in) launched = 1'b1;
      mul_valid_out = isdiv ? 1'($urandom % 2) : (launched && wc == lat);
      div_valid_out = isdiv ? (launched && wc == lat) : 1'($urandom % 2);
      if (!stall) done = 1'b1;
      else @(negedge clk);
    end
    total++; if (!done) begin bad++; $display("FAIL %s timeout stall stuck high", nm); end
    @(negedge clk);
    op_valid = 1'b0; mul_valid_out = 1'b0; div_valid_out = 1'b0;
    m_hi = exp[63:32]; m_lo = exp[31:0];
    #1;
    total++; if (stalls !== lat + 2) begin bad++; $display("FAIL %s stall_cycles got %0d want %0d", nm, stalls, lat + 2); end
    total++; if (mv !== (isdiv ? 0 : 1) || dv !== (isdiv ? 1 : 0)) begin bad++; $display("FAIL %s launch_pulses got mul=%0d div=%0d want %0d/%0d", nm, mv, dv, isdiv ? 0 : 1, isdiv ? 1 : 0); end
    total++; if (unit_a !== ma || unit_b !== mb) begin bad++; $display("FAIL %s unit_ops got %h/%h want %h/%h", nm, unit_a, unit_b, ma, mb); end
    total++; if (hi !== m_hi || lo !== m_lo) begin bad++; $display("FAIL %s hilo got %h/%h want %h/%h", nm, hi, lo, m_hi, m_lo); end
    op_valid = 1'b1; op = 4'd7;
    #1;
    total++; if (mf_result !== m_hi) begin bad++; $display("FAIL %s mfhi got %h want %h", nm, mf_result, m_hi); end
    op = 4'd8;
    #1;
    total++; if (mf_result !== m_lo) begin bad++; $display("FAIL %s mflo got %h want %h", nm, mf_result, m_lo); end
    op_valid = 1'b0;
  endtask
  task automatic test_mt_mf(input logic [31:0] vh, input logic [31:0] vl);
    @(negedge clk);
    op_valid = 1'b1; op = 4'd5; src_a = vh;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL mthi_stall got %b want 0", stall); end
    @(negedge clk);
    op = 4'd6; src_a = vl;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL mtlo_stall got %b want 0", stall); end
    @(negedge clk);
    m_hi = vh; m_lo = vl;
    op = 4'd7; src_a = 32'd0;
    #1;
    total++; if (mf_result !== vh) begin bad++; $display("FAIL mfhi got %h want %h", mf_result, vh); end
    op = 4'd8;
    #1;
    total++; if (mf_result !== vl) begin bad++; $display("FAIL mflo got %h want %h", mf_result, vl); end
    op = 4'd0;
    #1;
    total++; if (mf_result !== 32'd0) begin bad++; $display("FAIL mf_nop got %h want 0", mf_result); end
    op_valid = 1'b0;
  endtask
  task automatic test_div_zero(input logic [3:0] o);
    @(negedge clk);
    op_valid = 1'b1; op = o; src_a = 32'h1234; src_b = 32'd0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL dz_stall got %b want 0", stall); end
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_pulse got %b want 1", div_zero); end
    total++; if (div_valid_in !== 1'b0 || mul_valid_in !== 1'b0) begin bad++; $display("FAIL dz_launch got %b%b want 00", mul_valid_in, div_valid_in); end
    total++; if (hi !== m_hi || lo !== m_lo) begin bad++; $display("FAIL dz_hilo got %h/%h want %h/%h", hi, lo, m_hi, m_lo); end
    @(negedge clk);
    #1;
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL dz_pulse_end got %b want 0", div_zero); end
  endtask
  task automatic test_nop();
    for (int k = 0; k < 16; k++) begin
      if (k >= 1 && k <= 8) continue;
      @(negedge clk);
      op_valid = 1'b1; op = 4'(k); src_a = $urandom; src_b = $urandom;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL nop%0d_stall got %b want 0", k, stall); end
    end
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    total++; if (hi !== m_hi || lo !== m_lo) begin bad++; $display("FAIL nop_hilo got %h/%h want %h/%h", hi, lo, m_hi, m_lo); end
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    op_valid = 1'b1; op = 4'd2; src_a = 32'd3; src_b = 32'd4;
    mul_hi = 32'h5; mul_lo = 32'h6;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1; op_valid = 1'b0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rstmid_stall got %b want 0", stall); end
    total++; if (hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL rstmid_hilo got %h/%h want 0/0", hi, lo); end
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) @(negedge clk);
    mul_valid_out = 1'b1;
    @(negedge clk);
    mul_valid_out = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (stall !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL rstmid_late%0d got stall=%b hi=%h lo=%h want 0/0/0", k, stall, hi, lo); end
      @(negedge clk);
    end
    run_md(4'd2, 32'd6, 32'd7, 1, "multu_after_reset");
  endtask
  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h80000000;
      1: return 32'hFFFFFFFF;
      2: return $urandom % 16;
      3: return -($urandom % 16);
      default: return $urandom;
    endcase
  endfunction
  task automatic test_random();
    logic [3:0] o;
    logic [31:0] a, b;
    for (int n = 0; n < 40; n++) begin
      o = 4'(1 + $urandom % 4);
      a = pick();
      b = pick();
      if ((o == 4'd3 || o == 4'd4) && b == 32'd0) b = 32'd1;
      run_md(o, a, b, 1 + $urandom % 5, $sformatf("rand%0d_op%0d", n, o));
    end
  endtask
  initial begin
    test_reset();
    run_md(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, "multu_max");
    run_md(4'd1, 32'h80000000, 32'h80000000, 2, "mult_min");
    run_md(4'd1, -32'd3, 32'd5, 1, "mult_neg3x5");
    run_md(4'd3, -32'd7, 32'd2, 5, "div_neg7_2");
    run_md(4'd3, 32'h80000000, 32'hFFFFFFFF, 3, "div_min_neg1");
    test_mt_mf(32'h11, 32'h22);
    test_div_zero(4'd4);
    test_div_zero(4'd3);
    test_mt_mf(32'hDEADBEEF, 32'hCAFEF00D);
    test_nop();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
